// File: rtl/spi_slave_pkg.sv
// Shared widths, defaults and frame state encoding for the SPI slave.
package spi_slave_pkg;
  localparam int SPI_WORD_W      = 8;
  localparam int SPI_BITCNT_W    = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam logic [SPI_WORD_W-1:0] DEF_IDLE_FILL = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } frame_st_e;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, oversampled in the wb_clk_i domain, with one-byte tx holding
// register and one-byte rx output register.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int                    SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [SPI_WORD_W-1:0] IDLE_FILL   = DEF_IDLE_FILL
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  sclk_i,
  input  logic                  nss_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [SPI_WORD_W-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [SPI_WORD_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_overrun_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic nss_s, nss_rise, nss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i), .d(sclk_i),
    .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nss_sync (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i), .d(nss_i),
    .q(nss_s), .rise(nss_rise), .fall(nss_fall)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) mosi_sync <= '0;
    else             mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The nss chain resets high, so a low pin at release looks like a falling
  // edge; frames are only armed once a real high level has flushed through.
  logic [SETTLE_W-1:0] settle;
  logic                armed;
  logic                settled;

  assign settled = (settle == SETTLE_W'(SYNC_STAGES));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      if (!settled) settle <= settle + SETTLE_W'(1);
      if (settled && nss_s) armed <= 1'b1;
    end
  end

  frame_st_e state, state_nx;
  logic      start, frame_end;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= ST_IDLE;
    else             state <= state_nx;
  end

  // Mode 0 idles sclk low, so a frame only opens with the clock at rest.
  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: if (armed && nss_fall && !sclk_s) begin
        state_nx = ST_FRAME;
        start    = 1'b1;
      end
      ST_FRAME: if (nss_rise) begin
        state_nx  = ST_IDLE;
        frame_end = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  logic                    in_frame;
  logic                    sample, load, shift;
  logic [SPI_BITCNT_W-1:0] bitcnt;
  logic [SPI_WORD_W-1:0]   rx_shift, tx_shift, hold_data;
  logic                    hold_full, byte_done, tx_wr, rx_take;

  assign in_frame = (state == ST_FRAME) && !nss_rise;
  assign sample   = in_frame && sclk_rise;
  assign load     = start || (in_frame && sclk_fall && bitcnt == '0);
  assign shift    = in_frame && sclk_fall && bitcnt != '0;

  // A load frees the holding register in the same cycle it is read.
  assign tx_ready_o = !hold_full || load;
  assign tx_wr      = tx_valid_i && tx_ready_o;
  assign rx_take    = rx_valid_o && rx_ready_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      bitcnt        <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      hold_data     <= '0;
      hold_full     <= 1'b0;
      byte_done     <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      if (start || frame_end) bitcnt <= '0;
      else if (sample)        bitcnt <= bitcnt + SPI_BITCNT_W'(1);
      if (sample) rx_shift <= {rx_shift[SPI_WORD_W-2:0], mosi_s};
      byte_done <= sample && (bitcnt == '1);

      if (load)       tx_shift <= hold_full ? hold_data : IDLE_FILL;
      else if (shift) tx_shift <= {tx_shift[SPI_WORD_W-2:0], 1'b0};
      tx_underrun_o <= load && !hold_full;

      if (tx_wr) begin
        hold_data <= tx_data_i;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      rx_overrun_o <= byte_done && rx_valid_o && !rx_ready_i;
      if (byte_done) begin
        if (!rx_valid_o || rx_take) begin
          rx_data_o  <= rx_shift;
          rx_valid_o <= 1'b1;
        end
      end else if (rx_take) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o    = (state == ST_FRAME);
  assign miso_oe_o = busy_o;
  assign miso_o    = busy_o && tx_shift[SPI_WORD_W-1];
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master plus a byte-level expectation model.
module tb_spi_slave;
  localparam int         SYNC = 2;
  localparam logic [7:0] FILL = 8'hFF;
  localparam int         HALF = 6;   // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n, sclk, nss, mosi, miso, miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, rx_overrun, tx_underrun, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_under = 0, n_over = 0, rx_cyc = 0, rise_cyc = 0;
  logic rx_prev = 1'b0;
  logic [7:0] rx_got [$];
  logic [7:0] m_out [8];
  logic [7:0] m_in  [8];

  spi_slave #(.SYNC_STAGES(SYNC), .IDLE_FILL(FILL)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .sclk_i(sclk), .nss_i(nss), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready), .rx_overrun_o(rx_overrun), .tx_underrun_o(tx_underrun),
    .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    if (tx_underrun) n_under++;
    if (rx_overrun) n_over++;
    if (rx_valid && !rx_prev) rx_cyc = cyc;
    rx_prev = rx_valid;
  end

  task automatic q_tx(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 4000) begin @(negedge clk); t++; end
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL q_tx_timeout: tx_ready=%b, required 1", tx_ready);
    end
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_bit(input logic mo, output logic mi, input bit drop);
    mosi = mo;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1; mi = miso; rise_cyc = cyc;
    repeat (HALF) @(negedge clk);
    if (drop) sclk = 1'b0;
  endtask

  // sclk returns low only after nss is released, so the trailing falling edge
  // never pulls an extra byte out of the holding register.
  task automatic spi_frame(input int n);
    logic b_in;
    nss = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int b = 0; b < n; b++)
      for (int i = 7; i >= 0; i--) begin
        spi_bit(m_out[b][i], b_in, !(b == n-1 && i == 0));
        m_in[b][i] = b_in;
      end
    nss = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sclk = 1'b0; nss = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0)       begin errors++; $display("FAIL rst_miso: got %b want 0", miso); end
    checks++; if (miso_oe !== 1'b0)    begin errors++; $display("FAIL rst_oe: got %b want 0", miso_oe); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    checks++; if ({rx_overrun, tx_underrun} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b want 00", {rx_overrun, tx_underrun}); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic;
    int base = rx_got.size();
    int bu = n_under;
    logic b_in;
    q_tx(8'hA5);
    m_out[0] = 8'h3C;
    nss = 1'b0;
    repeat (2*HALF) @(negedge clk);
    checks++; if ({busy, miso_oe} !== 2'b11) begin errors++; $display("FAIL basic_busy_oe: got %b want 11", {busy, miso_oe}); end
    for (int i = 7; i >= 0; i--) begin
      spi_bit(m_out[0][i], b_in, i != 0);
      m_in[0][i] = b_in;
    end
    nss = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (2*HALF) @(negedge clk);
    checks++; if (m_in[0] !== 8'hA5) begin errors++; $display("FAIL basic_miso: got %h want a5", m_in[0]); end
    checks++; if (rx_got.size() - base != 1) begin errors++; $display("FAIL basic_rx_count: got %0d want 1", rx_got.size() - base); end
    else begin
      checks++; if (rx_got[base] !== 8'h3C) begin errors++; $display("FAIL basic_rx_data: got %h want 3c", rx_got[base]); end
    end
    checks++; if (rx_cyc - rise_cyc != SYNC + 2) begin errors++; $display("FAIL basic_rx_latency: got %0d want %0d", rx_cyc - rise_cyc, SYNC + 2); end
    checks++; if (n_under != bu) begin errors++; $display("FAIL basic_underrun: got %0d want 0", n_under - bu); end
    checks++; if ({busy, miso_oe, miso} !== 3'b000) begin errors++; $display("FAIL basic_idle_out: got %b want 000", {busy, miso_oe, miso}); end
  endtask

  task automatic test_underrun;
    logic [7:0] exp_in [3];
    int base = rx_got.size();
    int bu = n_under;
    q_tx(8'h55);
    m_out[0] = 8'h01; m_out[1] = 8'h02; m_out[2] = 8'h03;
    exp_in[0] = 8'h55; exp_in[1] = FILL; exp_in[2] = FILL;
    spi_frame(3);
    for (int k = 0; k < 3; k++) begin
      checks++; if (m_in[k] !== exp_in[k]) begin errors++; $display("FAIL under_miso%0d: got %h want %h", k, m_in[k], exp_in[k]); end
    end
    checks++; if (n_under - bu != 2) begin errors++; $display("FAIL under_pulses: got %0d want 2", n_under - bu); end
    checks++; if (rx_got.size() - base != 3) begin errors++; $display("FAIL under_rx_count: got %0d want 3", rx_got.size() - base); end
  endtask

  task automatic test_overrun;
    int bo = n_over;
    rx_ready = 1'b0;
    m_out[0] = 8'h11; m_out[1] = 8'h22;
    spi_frame(2);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL over_valid: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL over_data: got %h want 11", rx_data); end
    checks++; if (n_over - bo != 1) begin errors++; $display("FAIL over_pulses: got %0d want 1", n_over - bo); end
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL over_drain: got %b want 0", rx_valid); end
    checks++; if (rx_got[$] !== 8'h11) begin errors++; $display("FAIL over_consumed: got %h want 11", rx_got[$]); end
  endtask

  task automatic test_abort;
    int base = rx_got.size();
    int bu = n_under;
    logic b_in;
    nss = 1'b0;
    repeat (2*HALF) @(negedge clk);
    q_tx(8'h77);
    for (int i = 0; i < 5; i++) spi_bit(i[0], b_in, 1'b1);
    nss = 1'b1;
    repeat (2*HALF) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    for (int i = 0; i < 8; i++) spi_bit(1'b1, b_in, 1'b1);
    repeat (2*HALF) @(negedge clk);
    checks++; if (rx_got.size() != base || rx_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rx: got %0d bytes valid=%b want 0 bytes", rx_got.size() - base, rx_valid); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL abort_hold_kept: tx_ready=%b want 0", tx_ready); end
    bu = n_under;
    m_out[0] = 8'hC3;
    spi_frame(1);
    checks++; if (rx_got.size() - base != 1 || rx_got[$] !== 8'hC3) begin errors++; $display("FAIL abort_rx: got %0d bytes last %h want 1 byte c3", rx_got.size() - base, rx_got[$]); end
    checks++; if (m_in[0] !== 8'h77 || n_under != bu) begin errors++; $display("FAIL abort_tx: got %h under=%0d want 77 under=0", m_in[0], n_under - bu); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] f [4];
    int base = rx_got.size();
    int bu = n_under;
    for (int k = 0; k < 4; k++) begin
      f[k] = 8'($urandom());
      m_out[k] = 8'($urandom());
    end
    q_tx(f[0]);
    fork
      spi_frame(4);
      for (int k = 1; k < 4; k++) q_tx(f[k]);
    join
    for (int k = 0; k < 4; k++) begin
      checks++; if (m_in[k] !== f[k]) begin errors++; $display("FAIL b2b_miso%0d: got %h want %h", k, m_in[k], f[k]); end
      checks++; if (rx_got.size() <= base + k || rx_got[base+k] !== m_out[k]) begin errors++; $display("FAIL b2b_rx%0d: got %0d bytes want %h", k, rx_got.size() - base, m_out[k]); end
    end
    checks++; if (n_under != bu) begin errors++; $display("FAIL b2b_underrun: got %0d want 0", n_under - bu); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      logic [7:0] txb = 8'($urandom());
      logic       doq = 1'($urandom_range(0, 1));
      int base = rx_got.size();
      int bu = n_under;
      m_out[0] = 8'($urandom());
      if (doq) q_tx(txb);
      spi_frame(1);
      checks++; if (m_in[0] !== (doq ? txb : FILL)) begin errors++; $display("FAIL rand%0d_miso: got %h want %h", it, m_in[0], doq ? txb : FILL); end
      checks++; if (rx_got.size() - base != 1 || rx_got[$] !== m_out[0]) begin errors++; $display("FAIL rand%0d_rx: got %h want %h", it, rx_got[$], m_out[0]); end
      checks++; if (n_under - bu != int'(!doq)) begin errors++; $display("FAIL rand%0d_under: got %0d want %0d", it, n_under - bu, int'(!doq)); end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    int bu;
    logic b_in;
    nss = 1'b0;
    repeat (2*HALF) @(negedge clk);
    q_tx(8'hEE);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, b_in, i != 2);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({miso, miso_oe, busy} !== 3'b000) begin errors++; $display("FAIL rstmid_out: got %b want 000", {miso, miso_oe, busy}); end
    checks++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_hs: ready=%b valid=%b want 1 0", tx_ready, rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    base = rx_got.size();
    for (int i = 0; i < 8; i++) spi_bit(i[0], b_in, 1'b1);
    repeat (2*HALF) @(negedge clk);
    checks++; if (busy !== 1'b0 || rx_got.size() != base) begin errors++; $display("FAIL rstmid_no_frame: busy=%b bytes=%0d want 0 0", busy, rx_got.size() - base); end
    nss = 1'b1;
    repeat (2*HALF) @(negedge clk);
    bu = n_under;
    m_out[0] = 8'h69;
    spi_frame(1);
    checks++; if (rx_got.size() - base != 1 || rx_got[$] !== 8'h69) begin errors++; $display("FAIL rstmid_rx: got %0d bytes last %h want 69", rx_got.size() - base, rx_got[$]); end
    checks++; if (m_in[0] !== FILL || n_under - bu != 1) begin errors++; $display("FAIL rstmid_tx: got %h under=%0d want ff 1", m_in[0], n_under - bu); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underrun;
    test_overrun;
    test_abort;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (minimum 2).
REQ-002 The block SHALL have parameter IDLE_FILL, default 8'hFF, MISO byte sent when no transmit data is queued.
REQ-003 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 sclk_i  in  1  SPI clock from external master, mode 0 (CPOL=0, CPHA=0), asynchronous to wb_clk_i.
REQ-006 nss_i  in  1  active-low slave select, asynchronous.
REQ-007 mosi_i  in  1  master-out data, MSB first.
REQ-008 miso_o  out  1  slave-out data, MSB first.
REQ-009 miso_oe_o  out  1  MISO output enable; high only while a frame is active.
REQ-010 tx_data_i  in  8  byte to transmit.
REQ-011 tx_valid_i  in  1  tx_data_i valid.
REQ-012 tx_ready_o  out  1  transmit holding register empty.
REQ-013 rx_data_o  out  8  last received byte.
REQ-014 rx_valid_o  out  1  rx_data_o holds an unconsumed byte.
REQ-015 rx_ready_i  in  1  consumer accepts rx_data_o.
REQ-016 rx_overrun_o  out  1  one-cycle pulse: a byte was dropped because rx_valid_o was still set.
REQ-017 tx_underrun_o  out  1  one-cycle pulse: IDLE_FILL was loaded because the holding register was empty.
REQ-018 busy_o  out  1  frame active (synchronized nss low).

Function
REQ-019 sclk_i, nss_i and mosi_i SHALL pass through SYNC_STAGES flops; rising/falling edges are detected on synchronized sclk; sclk frequency SHALL be at most wb_clk_i/8.
REQ-020 Frame start = synchronized nss falling edge: bit counter cleared, shift-out register loaded from the holding register (or IDLE_FILL), busy_o and miso_oe_o set the next cycle.
REQ-021 On each synchronized sclk rising edge during a frame, synchronized mosi SHALL be shifted into the receive shift register LSB and the 3-bit bit counter SHALL increment modulo 8.
REQ-022 On each synchronized sclk falling edge: if the bit counter is 0 (byte just completed), the shift-out register SHALL load the next byte; otherwise it SHALL shift left one bit.
REQ-023 miso_o SHALL equal shift-out register bit 7 while busy_o is high and 0 otherwise.
REQ-024 Byte complete (counter wraps 7->0): rx_data_o and rx_valid_o SHALL update one cycle after the detected edge, i.e. SYNC_STAGES+2 wb_clk_i cycles after the pin edge.
REQ-025 rx handshake: rx_valid_o cleared on rx_valid_o & rx_ready_i; if a byte completes while rx_valid_o is set and not being accepted in the same cycle, the new byte SHALL be dropped, rx_data_o retained, rx_overrun_o pulsed; if accepted in the same cycle, the new byte is loaded and no overrun.
REQ-026 tx handshake: holding register written on tx_valid_i & tx_ready_o; a load into the shift-out register empties it; if write and load coincide while full, the load takes the old byte and the write is accepted in the same cycle.
REQ-027 Load with empty holding register SHALL use IDLE_FILL and pulse tx_underrun_o.
REQ-028 nss rising edge mid-byte SHALL abort: partial byte discarded, bit counter cleared, no rx_valid_o, busy_o and miso_oe_o cleared next cycle; the holding register is unaffected.
REQ-029 sclk edges while nss is high SHALL be ignored.

Reset
REQ-030 While wb_rst_n_i is low: all synchronizer flops 1 for nss and 0 for sclk/mosi; miso_o 0, miso_oe_o 0, busy_o 0, tx_ready_o 1, rx_valid_o 0, rx_data_o 8'h00, pulses 0, counters 0, holding register empty.
REQ-031 After reset release with nss_i already low, no frame SHALL start until nss is seen high then low.

Structure
REQ-032 Package spi_slave_pkg SHALL hold SPI_WORD_W=8, SPI_BITCNT_W=3, default IDLE_FILL and default SYNC_STAGES.
REQ-033 Sub-module spi_sync (parameterized synchronizer with rise/fall edge outputs) SHALL be used for sclk_i and nss_i; mosi_i uses a plain synchronizer.

Verification
REQ-034 Queue 8'hA5, master sends 8'h3C in one frame -> master receives 8'hA5, rx_data_o=8'h3C, one rx_valid_o.
REQ-035 Three-byte frame 8'h01,8'h02,8'h03 with only 8'h55 queued -> master receives 8'h55,8'hFF,8'hFF, two tx_underrun_o pulses.
REQ-036 Two bytes 8'h11,8'h22 with rx_ready_i held low -> rx_data_o=8'h11, one rx_overrun_o pulse.
REQ-037 nss raised after 5 bits, then full frame 8'hC3 -> no rx_valid_o for the aborted byte, then rx_data_o=8'hC3.
REQ-038 wb_rst_n_i pulsed low mid-byte with nss low -> all outputs at reset values; next byte received only after nss high then low.
